int_to_fp: RTL and testbench

- Multi-cycle converter from a 32-bit signed or unsigned integer to bfloat16 (1 sign, 8 exponent, 7 mantissa bits). It implements FCVT.BF16.W/WU, the inverse of the FPU's bf16-to-int path.
- Sits in the FPU next to the fp-to-int unit. It takes an operand from the issue side through a valid/ready handshake and returns the result and flags through a second valid/ready handshake.
- Normalisation is iterative: a left-shift of 8 or 1 per cycle, so the area stays small.

---
 rtl/int_to_fp_if.sv | 39 +++
 rtl/int_to_fp.sv | 134 +++++++++++++
 tb/tb_int_to_fp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_to_fp_if.sv
// int_to_fp_if: operand and result channels of the integer-to-bfloat16 converter.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where the producer's valid and the consumer's ready are both high.
// The consumer side of the operand channel is the converter (ready_o), and
// the consumer side of the result channel is the FPU writeback (result_ready_i).
// While valid is high and ready is low, the producer holds the payload stable.
//
// Signals:
//   valid_i         operand valid (issue -> converter)
//   ready_o         converter can accept an operand (IDLE only)
//   int_i[31:0]     integer operand
//   mode_i          1 = unsigned (WU), 0 = signed (W)
//   result_valid_o  fp_o/flag_o valid (converter -> writeback)
//   result_ready_i  writeback accepts the result
//   fp_o[15:0]      bfloat16 result
//   flag_o[2:0]     {inexact, underflow(0), overflow(0)}
interface int_to_fp_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] int_i;
  logic        mode_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [15:0] fp_o;
  logic [2:0]  flag_o;

  // master: issue side / writeback side (drives operand, accepts result)
  modport master (
    output valid_i, int_i, mode_i, result_ready_i,
    input  ready_o, result_valid_o, fp_o, flag_o
  );

  // slave: the converter itself
  modport slave (
    input  valid_i, int_i, mode_i, result_ready_i,
    output ready_o, result_valid_o, fp_o, flag_o
  );
endinterface

// File: rtl/int_to_fp.sv
// int_to_fp: multi-cycle 32-bit signed/unsigned integer to bfloat16 converter
// (FCVT.BF16.W / FCVT.BF16.WU). Normalisation shifts the magnitude left by 8
// or by 1 per cycle, then one cycle of round-to-nearest-even.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   flush_i   synchronous abort back to IDLE (priority over all handshakes)
//   bus       int_to_fp_if.slave operand/result channels
//   state_o   current FSM state (0 IDLE, 1 NORM, 2 ROUND, 3 DONE) for debug
module int_to_fp #(
  parameter int BIAS    = 127,
  parameter int EXP_TOP = BIAS + 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  int_to_fp_if.slave        bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] EXP_TOP_L = EXP_TOP[7:0];

  state_t      state_q, state_d;
  logic [31:0] mag_q;
  logic [4:0]  shcnt_q;
  logic        sign_q;
  logic [15:0] fp_q;
  logic [2:0]  flag_q;

  // Operand capture: magnitude of the operand under the selected signedness.
  // Signed 0x80000000 negates to itself, which is the correct magnitude.
  logic        cap_sign;
  logic [31:0] cap_mag;
  assign cap_sign = ~bus.mode_i & bus.int_i[31];
  assign cap_mag  = cap_sign ? (~bus.int_i + 32'd1) : bus.int_i;

  // Rounding: mag_q[31] is the hidden one once NORM is left.
  logic [6:0] m_trunc;
  logic       guard_bit;
  logic       sticky_bit;
  logic       round_up;
  logic [7:0] m_sum;
  logic [7:0] exp_r;
  assign m_trunc    = mag_q[30:24];
  assign guard_bit  = mag_q[23];
  assign sticky_bit = |mag_q[22:0];
  assign round_up   = guard_bit & (sticky_bit | m_trunc[0]);
  assign m_sum      = {1'b0, m_trunc} + {7'd0, round_up};
  // m_sum[7] is the mantissa carry-out; it bumps the exponent (max 159).
  assign exp_r      = EXP_TOP_L - {3'd0, shcnt_q} + {7'd0, m_sum[7]};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.valid_i) state_d = (cap_mag == 32'd0) ? DONE : NORM;
        NORM:    if (mag_q[31]) state_d = ROUND;
        ROUND:   state_d = DONE;
        DONE:    if (bus.result_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.ready_o        = (state_q == IDLE);
    bus.result_valid_o = (state_q == DONE);
    state_o            = state_q;
  end

  assign bus.fp_o   = fp_q;
  assign bus.flag_o = flag_q;

  // Datapath: magnitude/shift count during NORM, result registers written
  // only on zero-operand capture and on leaving ROUND.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mag_q   <= '0;
      shcnt_q <= '0;
      sign_q  <= 1'b0;
      fp_q    <= '0;
      flag_q  <= '0;
    end else if (!flush_i) begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            sign_q  <= cap_sign;
            mag_q   <= cap_mag;
            shcnt_q <= '0;
            if (cap_mag == 32'd0) begin
              fp_q   <= 16'h0000;
              flag_q <= 3'b000;
            end
          end
        end
        NORM: begin
          if (!mag_q[31]) begin
            if (mag_q[31:24] == 8'd0) begin
              mag_q   <= {mag_q[23:0], 8'd0};
              shcnt_q <= shcnt_q + 5'd8;
            end else begin
              mag_q   <= {mag_q[30:0], 1'b0};
              shcnt_q <= shcnt_q + 5'd1;
            end
          end
        end
        ROUND: begin
          fp_q   <= {sign_q, exp_r, m_sum[6:0]};
          flag_q <= {guard_bit | sticky_bit, 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: directed and randomized checks of int_to_fp against an
// arithmetic reference model (value-level rounding, not bit-level shifting).
module tb_int_to_fp;
  localparam int W = 19;  // {flag[2:0], fp[15:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] last_exp;

  int_to_fp_if bus();

  int_to_fp dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: round |value| to 8 significant bits, nearest-even.
  function automatic logic [W-1:0] ref_model(input logic [31:0] val, input logic mode,
                                             output int lat);
    longint sv, mag, keep, rem, half;
    int     p, e, drop, lz;
    logic   s, inexact;
    sv = mode ? longint'({32'd0, val}) : longint'($signed(val));
    s  = (sv < 0);
    mag = s ? -sv : sv;
    if (mag == 0) begin
      lat = 1;
      return '0;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 127 + p;
    if (p <= 7) begin
      keep    = mag << (7 - p);
      inexact = 1'b0;
    end else begin
      drop    = p - 7;
      keep    = mag >> drop;
      rem     = mag - (keep << drop);
      half    = longint'(1) << (drop - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == 256) begin
        keep = 128;
        e++;
      end
    end
    lz  = 31 - p;
    lat = lz / 8 + lz % 8 + 1 + 2;
    return {inexact, 2'b00, s, e[7:0], keep[6:0]};
  endfunction

  // ---------------- driver ----------------
  // Issues one operand, waits for the result, holds it for `hold` cycles of
  // backpressure (pulsing valid_i meanwhile), then releases it.
  task automatic run_op(input logic [31:0] val, input logic mode, input int hold,
                        output logic [15:0] obs_fp, output logic [2:0] obs_flag);
    logic [W-1:0] e;
    int           el, lat;
    e = ref_model(val, mode, el);
    exp_q.push_back(e);
    lat_q.push_back(el);

    @(negedge clk);
    check("ready_idle", bus.ready_o, 1);
    bus.valid_i = 1'b1;
    bus.int_i   = val;
    bus.mode_i  = mode;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.result_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    last_exp = e;
    check("result_valid", bus.result_valid_o, 1);
    check("latency", lat, el);
    check("fp", bus.fp_o, e[15:0]);
    check("flag", bus.flag_o, e[18:16]);
    check("ready_done", bus.ready_o, 0);
    obs_fp   = bus.fp_o;
    obs_flag = bus.flag_o;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.int_i   = $urandom;
      bus.mode_i  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("bp_fp", bus.fp_o, e[15:0]);
      check("bp_flag", bus.flag_o, e[18:16]);
      check("bp_ready", bus.ready_o, 0);
      check("bp_valid", bus.result_valid_o, 1);
    end

    @(negedge clk);
    bus.valid_i        = 1'b0;
    bus.result_ready_i = 1'b1;
    @(posedge clk); #1;
    check("release_valid", bus.result_valid_o, 0);
    check("release_ready", bus.ready_o, 1);
    @(negedge clk);
    bus.result_ready_i = 1'b0;
  endtask

  task automatic start_long_op();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.int_i   = 32'h1;
    bus.mode_i  = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("mid_norm_state", dbg_state, 1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.result_valid_o) seen++;
    end
    check(tag, seen, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] ofp;
  logic [2:0]  ofl;

  initial begin
    rst                = 1'b1;
    flush              = 1'b0;
    bus.valid_i        = 1'b0;
    bus.int_i          = '0;
    bus.mode_i         = 1'b0;
    bus.result_ready_i = 1'b0;
    last_exp           = '0;

    #1;
    check("rst_ready", bus.ready_o, 1);
    check("rst_valid", bus.result_valid_o, 0);
    check("rst_fp", bus.fp_o, 16'h0000);
    check("rst_flag", bus.flag_o, 3'b000);
    check("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(32'h0000_0001, 1'b0, 0, ofp, ofl);
    check("s1_fp", ofp, 16'h3F80);   check("s1_flag", ofl, 3'b000);
    run_op(32'hFFFF_FFFF, 1'b0, 0, ofp, ofl);
    check("sm1_fp", ofp, 16'hBF80);  check("sm1_flag", ofl, 3'b000);
    run_op(32'h8000_0000, 1'b0, 0, ofp, ofl);
    check("smin_fp", ofp, 16'hCF00); check("smin_flag", ofl, 3'b000);
    run_op(32'h0000_0000, 1'b0, 0, ofp, ofl);
    check("z0_fp", ofp, 16'h0000);   check("z0_flag", ofl, 3'b000);
    run_op(32'hFFFF_FFFF, 1'b1, 0, ofp, ofl);
    check("umax_fp", ofp, 16'h4F80); check("umax_flag", ofl, 3'b100);
    run_op(32'h0000_0000, 1'b1, 0, ofp, ofl);
    check("z1_fp", ofp, 16'h0000);   check("z1_flag", ofl, 3'b000);
    run_op(32'h0000_0181, 1'b1, 0, ofp, ofl);
    check("tie_even_fp", ofp, 16'h43C0); check("tie_even_flag", ofl, 3'b100);
    run_op(32'h0000_0183, 1'b1, 5, ofp, ofl);
    check("tie_up_fp", ofp, 16'h43C2);   check("tie_up_flag", ofl, 3'b100);

    // Flush mid-NORM: back to IDLE, no result, outputs keep last values.
    start_long_op();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_valid", bus.result_valid_o, 0);
    check("flush_ready", bus.ready_o, 1);
    check("flush_fp", bus.fp_o, last_exp[15:0]);
    check("flush_flag", bus.flag_o, last_exp[18:16]);
    @(negedge clk);
    flush = 1'b0;
    expect_quiet("flush_no_result", 15);

    // Reset mid-NORM: immediate reset values, no result.
    start_long_op();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ready", bus.ready_o, 1);
    check("arst_valid", bus.result_valid_o, 0);
    check("arst_fp", bus.fp_o, 16'h0000);
    check("arst_flag", bus.flag_o, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("arst_no_result", 15);

    run_op(32'h0000_0007, 1'b0, 0, ofp, ofl);
    check("s7_fp", ofp, 16'h40E0); check("s7_flag", ofl, 3'b000);

    // Randomized operands spanning all leading-zero counts
    for (int n = 0; n < 40; n++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      run_op(v, 1'($urandom_range(0, 1)), $urandom_range(0, 2), ofp, ofl);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
